// File: rtl/sao_lcu_feeder_if.sv
// SAO input stream: pixel/parameter bus from the LCU feeder into the SAO core,
// with SAO's busy back-pressure flowing the other way.
interface sao_lcu_feeder_if;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic        busy;

    modport master (
        output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
               lcu_x, lcu_y,
        input  busy
    );

    modport slave (
        input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
               lcu_x, lcu_y,
        output busy
    );
endinterface

// File: rtl/sao_lcu_feeder.sv
// LCU feeder for SAO: reads a raster-order image ROM and a per-LCU parameter
// ROM, and streams pixels in LCU order (LCUs raster, pixels raster inside
// each LCU) with busy back-pressure. A 4-entry skid FIFO plus a bypass path
// hides the 1-cycle ROM latency so a full-rate stream is kept within an LCU.
module sao_lcu_feeder #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       lcu_size,
    output logic [AW-1:0]    img_addr,
    input  logic [7:0]       img_q,
    output logic [5:0]       par_addr,
    input  logic [23:0]      par_q,
    output logic             done,
    sao_lcu_feeder_if.master sao
);
    localparam int LOG_W = $clog2(IMG_W);
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {IDLE, PARAM, STREAM, FIN} state_t;
    state_t state;

    logic [1:0]  sz;                 // latched min(lcu_size, 2)
    logic [2:0]  lx, ly;             // current LCU column / row
    logic [5:0]  fx, fy;             // next pixel to fetch inside the LCU
    logic        fetching;           // pixels of the current LCU still to fetch
    logic        pending;            // img_q carries a fetched pixel this cycle
    logic        cap_par;            // par_q carries this LCU's parameters
    logic [7:0]  fifo [DEPTH];
    logic [1:0]  wptr, rptr;
    logic [2:0]  cnt;
    logic [11:0] ocnt;               // transfers done inside the current LCU
    logic        valid;
    logic [7:0]  pix;
    logic [1:0]  typ;
    logic [4:0]  band;
    logic        eo;
    logic [15:0] offs;

    logic [5:0]    s_last;
    logic [2:0]    gx_last, gy_last;
    logic [11:0]   px_last;
    logic          last_lcu, xfer, ready, avail, push, pop, issue;
    logic [7:0]    head;
    logic [AW-1:0] row, col;

    // Geometry for the latched LCU size, handshake decode and ROM addresses
    always_comb begin
        s_last   = 6'((16 << sz) - 1);
        gx_last  = 3'((IMG_W >> (4 + int'(sz))) - 1);
        gy_last  = 3'((IMG_H >> (4 + int'(sz))) - 1);
        px_last  = 12'((256 << (2 * int'(sz))) - 1);
        last_lcu = (lx == gx_last) && (ly == gy_last);
        xfer     = valid && !sao.busy;
        ready    = !valid || !sao.busy;
        avail    = (cnt != 3'd0) || pending;
        head     = (cnt != 3'd0) ? fifo[rptr] : img_q;
        pop      = ready && (cnt != 3'd0);
        // A returning pixel skips the FIFO when it can go straight out
        push     = pending && !(ready && (cnt == 3'd0));
        // Never have more pixels stored or in flight than the FIFO can hold
        issue    = fetching && (({1'b0, cnt} + {3'b0, pending}) < 4'(DEPTH));
        row      = (AW'(ly) << (4 + int'(sz))) + AW'(fy);
        col      = (AW'(lx) << (4 + int'(sz))) + AW'(fx);
        img_addr = (row << LOG_W) + col;
        par_addr = 6'((int'(ly) << (LOG_W - 4 - int'(sz))) + int'(lx));
    end

    // Skid storage for pixels that return while the output is stalled
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= img_q;
    end

    // Frame FSM, fetch counters, FIFO pointers and the registered output stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            sz       <= 2'd0;
            lx       <= 3'd0;
            ly       <= 3'd0;
            fx       <= 6'd0;
            fy       <= 6'd0;
            fetching <= 1'b0;
            pending  <= 1'b0;
            cap_par  <= 1'b0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            cnt      <= 3'd0;
            ocnt     <= 12'd0;
            valid    <= 1'b0;
            pix      <= 8'd0;
            typ      <= 2'd0;
            band     <= 5'd0;
            eo       <= 1'b0;
            offs     <= 16'd0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            cap_par <= 1'b0;
            pending <= issue;
            if (issue) begin
                if (fx == s_last) begin
                    fx <= 6'd0;
                    if (fy == s_last) begin
                        fy       <= 6'd0;
                        fetching <= 1'b0;
                    end else begin
                        fy <= fy + 6'd1;
                    end
                end else begin
                    fx <= fx + 6'd1;
                end
            end
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            cnt <= 3'(cnt + {2'b0, push} - {2'b0, pop});
            // Output only advances when empty or when SAO takes the pixel
            if (ready) begin
                valid <= avail;
                if (avail) pix <= head;
            end
            // Parameters land together with the first pixel of the LCU
            if (cap_par) begin
                typ  <= par_q[23:22];
                band <= par_q[21:17];
                eo   <= par_q[16];
                offs <= par_q[15:0];
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sz       <= (lcu_size == 2'd3) ? 2'd2 : lcu_size;
                        lx       <= 3'd0;
                        ly       <= 3'd0;
                        ocnt     <= 12'd0;
                        fetching <= 1'b1;
                        state    <= PARAM;
                    end
                end
                PARAM: begin
                    cap_par <= 1'b1;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (xfer) begin
                        if (ocnt == px_last) begin
                            ocnt <= 12'd0;
                            if (last_lcu) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                if (lx == gx_last) begin
                                    lx <= 3'd0;
                                    ly <= ly + 3'd1;
                                end else begin
                                    lx <= lx + 3'd1;
                                end
                                fetching <= 1'b1;
                                state    <= PARAM;
                            end
                        end else begin
                            ocnt <= ocnt + 12'd1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign sao.in_en        = valid;
    assign sao.din          = pix;
    assign sao.sao_type     = typ;
    assign sao.sao_band_pos = band;
    assign sao.sao_eo_class = eo;
    assign sao.sao_offset   = offs;
    assign sao.lcu_x        = lx;
    assign sao.lcu_y        = ly;
endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Testbench for sao_lcu_feeder: ROM models, a transfer recorder, a busy
// driver, a table of hand-computed transfer vectors and a stream model.
module tb_sao_lcu_feeder;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  lcu_size;
    logic [13:0] img_addr;
    logic [7:0]  img_q;
    logic [5:0]  par_addr;
    logic [23:0] par_q;
    logic        done;

    sao_lcu_feeder_if sif();

    sao_lcu_feeder #(.IMG_W(128), .IMG_H(128), .AW(14)) dut (
        .clk(clk), .reset(reset), .start(start), .lcu_size(lcu_size),
        .img_addr(img_addr), .img_q(img_q), .par_addr(par_addr), .par_q(par_q),
        .done(done), .sao(sif)
    );

    int checks = 0;
    int errors = 0;
    int xcnt = 0;
    int done_cnt = 0;
    int bmode = 0;
    bit hold_arm = 0;
    logic [7:0]  held_din = 8'd0;
    logic [37:0] snap;
    logic [43:0] rec [16384];

    typedef struct {
        int         frame;
        int         k;
        int         addr;
        logic [2:0] lx;
        logic [2:0] ly;
        logic [5:0] pa;
    } vec_t;
    vec_t tbl [13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int a);
        int t;
        t = a * 13 + (a >> 7) * 71 + (a >> 3);
        return t[7:0];
    endfunction

    function automatic logic [23:0] par_word(input int n);
        logic [23:0] w;
        w[23:22] = 2'(n);
        w[21:17] = 5'(n * 7 + 3);
        w[16]    = n[0] ^ n[2];
        w[15:0]  = 16'(n * 4099 + 4660);
        return w;
    endfunction

    function automatic logic [37:0] cur_out();
        return {sif.din, sif.sao_type, sif.sao_band_pos, sif.sao_eo_class,
                sif.sao_offset, sif.lcu_x, sif.lcu_y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Synchronous image and parameter ROMs (data valid the cycle after address)
    always @(posedge clk) begin
        img_q <= pix(int'(img_addr));
        par_q <= par_word(int'(par_addr));
    end

    // Record every transfer and count done pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (reset && sif.in_en && !sif.busy) begin
            if (xcnt < 16384)
                rec[xcnt] = {sif.din, sif.lcu_x, sif.lcu_y, par_addr, sif.sao_type,
                             sif.sao_band_pos, sif.sao_eo_class, sif.sao_offset};
            xcnt++;
        end
        if (done) done_cnt++;
    end

    // Busy driver: idle, 50% random, or a 10-cycle stall on pixel 1000
    always begin
        @(posedge clk); #1;
        if (bmode == 1) begin
            sif.busy = 1'($urandom_range(0, 1));
        end else if (bmode == 2 && hold_arm && xcnt == 1000 && sif.in_en) begin
            snap     = cur_out();
            held_din = sif.din;
            sif.busy = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                chk($sformatf("hold_stable_%0d", i), cur_out(), snap);
            end
            sif.busy = 1'b0;
            hold_arm = 0;
        end else begin
            sif.busy = 1'b0;
        end
    end

    task automatic run_frame(input logic [1:0] size, input bit mid_start);
        int cyc;
        xcnt = 0;
        done_cnt = 0;
        lcu_size = size;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!sif.in_en && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("first_in_en_within_3", cyc <= 3, 1);
        if (mid_start) begin
            cyc = 0;
            while (xcnt < 3000 && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
            end
            lcu_size = 2'd0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lcu_size = size;
        end
        cyc = 0;
        while (!done && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("xfer_count", xcnt, 16384);
        chk("done_pulses", done_cnt, 1);
        chk("in_en_after_done", sif.in_en, 0);
    endtask

    task automatic check_table(input int f);
        logic [43:0] e;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].frame == f) begin
                e = {pix(tbl[i].addr), tbl[i].lx, tbl[i].ly, tbl[i].pa,
                     par_word(int'(tbl[i].pa))};
                chk($sformatf("vec%0d_f%0d_k%0d", i, f, tbl[i].k), rec[tbl[i].k], e);
            end
        end
    endtask

    task automatic check_stream(input string name, input int size);
        int s, per, n, w, py, px, gw, lxe, lye, addr, bad, first;
        logic [43:0] e;
        s = 16 << ((size > 2) ? 2 : size);
        per = s * s;
        gw = 128 / s;
        bad = 0;
        first = -1;
        for (int k = 0; k < 16384; k++) begin
            n = k / per;
            w = k % per;
            py = w / s;
            px = w % s;
            lxe = n % gw;
            lye = n / gw;
            addr = (lye * s + py) * 128 + lxe * s + px;
            e = {pix(addr), 3'(lxe), 3'(lye), 6'(n), par_word(n)};
            if (rec[k] !== e) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (first >= 0) $display("%s: first differing transfer k=%0d", name, first);
        chk(name, bad, 0);
    endtask

    initial begin
        int cyc;
        tbl[0]  = '{0, 0,     0,     3'd0, 3'd0, 6'd0};
        tbl[1]  = '{0, 1,     1,     3'd0, 3'd0, 6'd0};
        tbl[2]  = '{0, 63,    63,    3'd0, 3'd0, 6'd0};
        tbl[3]  = '{0, 64,    128,   3'd0, 3'd0, 6'd0};
        tbl[4]  = '{0, 4096,  64,    3'd1, 3'd0, 6'd1};
        tbl[5]  = '{0, 16383, 16383, 3'd1, 3'd1, 6'd3};
        tbl[6]  = '{1, 2304,  2064,  3'd1, 3'd1, 6'd9};
        tbl[7]  = '{1, 2320,  2192,  3'd1, 3'd1, 6'd9};
        tbl[8]  = '{1, 1000,  1848,  3'd3, 3'd0, 6'd3};
        tbl[9]  = '{2, 1024,  32,    3'd1, 3'd0, 6'd1};
        tbl[10] = '{2, 16383, 16383, 3'd3, 3'd3, 6'd15};
        tbl[11] = '{3, 0,     0,     3'd0, 3'd0, 6'd0};
        tbl[12] = '{3, 4096,  64,    3'd1, 3'd0, 6'd1};

        reset = 1'b0;
        start = 1'b0;
        lcu_size = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_en", sif.in_en, 0);
        chk("rst_done", done, 0);
        chk("rst_img_addr", img_addr, 0);
        chk("rst_par_addr", par_addr, 0);
        chk("rst_din", sif.din, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 64x64 LCUs, no back-pressure
        run_frame(2'd2, 1'b0);
        check_table(0);
        check_stream("stream_size2", 2);

        // 16x16 LCUs with a 10-cycle stall on pixel 1000
        bmode = 2;
        hold_arm = 1;
        run_frame(2'd0, 1'b0);
        chk("hold_happened", hold_arm, 0);
        chk("hold_pixel_sent", rec[1000][43:36], held_din);
        check_table(1);
        check_stream("stream_size0_hold", 0);

        // 32x32 LCUs with random busy
        bmode = 1;
        run_frame(2'd1, 1'b0);
        bmode = 0;
        @(posedge clk); #1;
        check_table(2);
        check_stream("stream_size1_random_busy", 1);

        // Reset at transfer 500, then a size-3 frame with a mid-frame start
        xcnt = 0;
        lcu_size = 2'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (xcnt < 500 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_500", xcnt >= 500, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_en_a", sif.in_en, 0);
        chk("midrst_done_a", done, 0);
        @(posedge clk); #1;
        chk("midrst_in_en_b", sif.in_en, 0);
        chk("midrst_done_b", done, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", sif.in_en, 0);
        run_frame(2'd3, 1'b1);
        check_table(3);
        check_stream("stream_size3_restart", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
